// File: rtl/mode_mux_pkg.sv
// Shared definitions for the mode selector: index width helper, state codes,
// and default timing for a 12 MHz board clock.
// Ports: none (package).
package mode_mux_pkg;

  // Width of a mode index; a single mode still needs one bit on the port.
  function automatic int mw(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  localparam logic [0:0] SHOW = 1'b0;  // mode number on LEDs, TX idle
  localparam logic [0:0] RUN  = 1'b1;  // selected circuit passed through

  localparam int DEF_DEB_CYCLES  = 120000;    // 10 ms at 12 MHz
  localparam int DEF_SHOW_CYCLES = 12000000;  // 1 s at 12 MHz

endpackage

// File: rtl/mode_mux_btn_pulse.sv
// Button conditioner: 2-FF synchroniser, stability debounce, rising-edge pulse.
// Latency: pulse 2 sync stages + DEB_CYCLES stable samples after the press; no backpressure.
// Ports: clk, rst (sync, active-high), sw_in (raw button), pulse (1-cycle press).
module btn_pulse #(
  parameter int DEB_CYCLES = mode_mux_pkg::DEF_DEB_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic sw_in,
  output logic pulse
);

  localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

  logic          s1;
  logic          s2;
  logic          deb;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      deb   <= 1'b0;
      cnt   <= '0;
      pulse <= 1'b0;
    end else begin
      s1    <= sw_in;
      s2    <= s1;
      pulse <= 1'b0;
      // Count consecutive samples that disagree with the debounced level;
      // any agreeing sample restarts the count, so bounces never get through.
      if (s2 == deb) begin
        cnt <= '0;
      end else if (cnt == CW'(DEB_CYCLES - 1)) begin
        deb   <= s2;
        cnt   <= '0;
        pulse <= s2;  // only the rising transition is a press
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/mode_mux.sv
// Test-program selector: NEXT/PREV step the mode, ACT pulses the selected mode,
// mode number is shown on the LEDs for SHOW_CYCLES after each change.
// Latency: all outputs registered, 1 cycle from led_in/tx_in; no backpressure.
// Ports: clk, rst, btn_next/btn_prev/btn_act (raw), led_in/tx_in (per-mode buses),
//        ledb, tx, mode, act (one-hot pulse), changed (pulse).
module mode_mux
  import mode_mux_pkg::*;
#(
  parameter int               NMODES      = 4,
  parameter int               LEDW        = 8,
  parameter int               DEB_CYCLES  = DEF_DEB_CYCLES,
  parameter int               SHOW_CYCLES = DEF_SHOW_CYCLES,
  parameter logic [NMODES-1:0] TX_MASK    = 4'b1100
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   btn_next,
  input  logic                   btn_prev,
  input  logic                   btn_act,
  input  logic [NMODES*LEDW-1:0] led_in,
  input  logic [NMODES-1:0]      tx_in,
  output logic [LEDW-1:0]        ledb,
  output logic                   tx,
  output logic [mw(NMODES)-1:0]  mode,
  output logic [NMODES-1:0]      act,
  output logic                   changed
);

  localparam int MW = mw(NMODES);
  localparam int TW = (SHOW_CYCLES > 1) ? $clog2(SHOW_CYCLES) : 1;
  localparam logic [NMODES-1:0] ACT_ONE = 1;

  logic          p_next;
  logic          p_prev;
  logic          p_act;
  logic [0:0]    state;
  logic [TW-1:0] timer;
  logic [MW-1:0] mode_nxt;
  logic          mode_chg;
  logic [LEDW-1:0] led_arr [NMODES];

  btn_pulse #(.DEB_CYCLES(DEB_CYCLES)) u_next (.clk(clk), .rst(rst), .sw_in(btn_next), .pulse(p_next));
  btn_pulse #(.DEB_CYCLES(DEB_CYCLES)) u_prev (.clk(clk), .rst(rst), .sw_in(btn_prev), .pulse(p_prev));
  btn_pulse #(.DEB_CYCLES(DEB_CYCLES)) u_act  (.clk(clk), .rst(rst), .sw_in(btn_act),  .pulse(p_act));

  for (genvar i = 0; i < NMODES; i++) begin : g_led
    assign led_arr[i] = led_in[i*LEDW +: LEDW];
  end

  // Explicit wrap at NMODES-1 keeps the index legal for non-power-of-two
  // mode counts; simultaneous NEXT and PREV cancel.
  always_comb begin
    mode_nxt = mode;
    if (p_next && !p_prev) begin
      mode_nxt = (mode >= MW'(NMODES - 1)) ? '0 : mode + 1'b1;
    end else if (p_prev && !p_next) begin
      mode_nxt = (mode == '0) ? MW'(NMODES - 1) : mode - 1'b1;
    end
  end

  assign mode_chg = (mode_nxt != mode);

  always_ff @(posedge clk) begin
    if (rst) begin
      mode    <= '0;
      state   <= SHOW;
      timer   <= '0;
      ledb    <= '0;
      tx      <= 1'b1;
      act     <= '0;
      changed <= 1'b0;
    end else begin
      mode    <= mode_nxt;
      changed <= mode_chg;
      // ACT uses the pre-update mode, so a press landing with a mode change
      // still reaches the circuit the user was looking at.
      act <= (p_act && state == RUN) ? (ACT_ONE << mode) : '0;

      if (state == SHOW) begin
        ledb <= LEDW'(mode);
        tx   <= 1'b1;
      end else begin
        ledb <= led_arr[mode];
        tx   <= TX_MASK[mode] ? tx_in[mode] : 1'b1;
      end

      if (mode_chg) begin
        state <= SHOW;
        timer <= '0;
      end else if (state == SHOW) begin
        if (timer == TW'(SHOW_CYCLES - 1)) begin
          state <= RUN;
        end else begin
          timer <= timer + 1'b1;
        end
      end
    end
  end

endmodule
